// File: rtl/z_event_monitor_pkg.sv
// Shared encodings and defaults for the z event monitor.
// Build option: ZMON_SYNC2_EN selects a two-flop z_in synchronizer.
package z_event_monitor_pkg;

    localparam int ZMON_CNT_W  = 8;
    localparam int ZMON_WINDOW = 16;

    typedef enum logic [1:0] {
        ZMON_IDLE   = 2'd0,
        ZMON_COUNT  = 2'd1,
        ZMON_REPORT = 2'd2
    } zmon_state_e;

endpackage

// File: rtl/zmon_edge_det.sv
// Samples asynchronous z_in and flags its rising edges.
// Build option: ZMON_SYNC2_EN adds a second synchronizer stage.
module zmon_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic z_in,
    output logic rise
);

    logic z_s;
    logic z_prev;

`ifdef ZMON_SYNC2_EN
    logic z_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_meta <= 1'b0;
            z_s    <= 1'b0;
            z_prev <= 1'b0;
        end else begin
            z_meta <= z_in;
            z_s    <= z_meta;
            z_prev <= z_s;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_s    <= 1'b0;
            z_prev <= 1'b0;
        end else begin
            z_s    <= z_in;
            z_prev <= z_s;
        end
    end
`endif

    assign rise = z_s & ~z_prev;

endmodule

// File: rtl/z_event_monitor.sv
// Counts z rising edges per fixed window and hands each count downstream.
// Build option: ZMON_SYNC2_EN (two-flop synchronizer in zmon_edge_det).
module z_event_monitor
    import z_event_monitor_pkg::*;
#(
    parameter int CNT_W  = ZMON_CNT_W,
    parameter int WINDOW = ZMON_WINDOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z_in,
    input  logic             en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow,
    output logic             busy
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    zmon_state_e      state;
    logic [CNT_W-1:0] ev_cnt;
    logic [CNT_W-1:0] ev_next;
    logic [WIN_W-1:0] win_cnt;
    logic             ovf;
    logic             ovf_next;
    logic             rise;

    zmon_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .z_in (z_in),
        .rise (rise)
    );

    // Saturating event count including the current cycle's edge
    always_comb begin
        ev_next  = ev_cnt;
        ovf_next = ovf;
        if (rise) begin
            if (&ev_cnt) begin
                ovf_next = 1'b1;
            end else begin
                ev_next = ev_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ZMON_IDLE;
            ev_cnt    <= '0;
            win_cnt   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ZMON_IDLE: begin
                    if (en) begin
                        state   <= ZMON_COUNT;
                        busy    <= 1'b1;
                        ev_cnt  <= '0;
                        win_cnt <= '0;
                        ovf     <= 1'b0;
                    end
                end
                ZMON_COUNT: begin
                    ev_cnt  <= ev_next;
                    ovf     <= ovf_next;
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (win_cnt == WIN_LAST) begin
                        state     <= ZMON_REPORT;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_count <= ev_next;
                        overflow  <= ovf_next;
                    end
                end
                ZMON_REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (en) begin
                            state   <= ZMON_COUNT;
                            busy    <= 1'b1;
                            ev_cnt  <= '0;
                            win_cnt <= '0;
                            ovf     <= 1'b0;
                        end else begin
                            state <= ZMON_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ZMON_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z_event_monitor.sv
// Bench for z_event_monitor: default instance plus a CNT_W=2, WINDOW=32 one.
// Expected counts come from a log of z_in samples and the window rules.
module tb_z_event_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       z_in = 1'b0;
    logic       en0 = 1'b0;
    logic       rdy0 = 1'b0;
    logic       en1 = 1'b0;
    logic       rdy1 = 1'b0;
    logic       v0, o0, b0;
    logic [7:0] c0;
    logic       v1, o1, b1;
    logic [1:0] c1;

    int checks = 0;
    int failures = 0;
    bit zlog[$];
    int last_cnt;
    int last_ovf;

    always #5 clk = ~clk;

    // z_in value seen at each rising edge, indexed by edge number
    always @(posedge clk) zlog.push_back(z_in);

    z_event_monitor u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .z_in      (z_in),
        .en        (en0),
        .out_ready (rdy0),
        .out_valid (v0),
        .out_count (c0),
        .overflow  (o0),
        .busy      (b0)
    );

    z_event_monitor #(
        .CNT_W  (2),
        .WINDOW (32)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .z_in      (z_in),
        .en        (en1),
        .out_ready (rdy1),
        .out_valid (v1),
        .out_count (c1),
        .overflow  (o1),
        .busy      (b1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Rising transitions of sampled z within the window started at edge p
    function automatic int model_rises(input int p, input int w);
        int off;
        int n;
`ifdef ZMON_SYNC2_EN
        off = 1;
`else
        off = 0;
`endif
        n = 0;
        for (int j = p - off; j < p + w - off; j++) begin
            if (zlog[j] && !zlog[j-1]) n++;
        end
        return n;
    endfunction

    task automatic start(input bit sel, input bit env, input bit zv,
                         input bit rdy, output int p);
        if (sel) begin
            en1 = env;
            rdy1 = rdy;
        end else begin
            en0 = env;
            rdy0 = rdy;
        end
        z_in = zv;
        p = zlog.size();
        step();
        en0 = 1'b0;
        en1 = 1'b0;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
    endtask

    task automatic hs(input bit sel, input bit env, input bit zv,
                      input string tag, output int p);
        start(sel, env, zv, 1'b1, p);
        check({tag, "_hs_valid"}, sel ? v1 : v0, 0);
        check({tag, "_hs_busy"}, sel ? b1 : b0, 32'(env));
    endtask

    task automatic body(input bit sel, input int w, input logic [63:0] pat,
                        input int p, input string tag);
        int n;
        int cmax;
        for (int i = 1; i <= w; i++) begin
            z_in = pat[i];
            step();
            if (i < w) begin
                check({tag, "_busy"}, sel ? b1 : b0, 1);
                check({tag, "_nvalid"}, sel ? v1 : v0, 0);
            end
        end
        n = model_rises(p, w);
        cmax = sel ? 3 : 255;
        last_cnt = (n > cmax) ? cmax : n;
        last_ovf = (n > cmax) ? 1 : 0;
        check({tag, "_valid"}, sel ? v1 : v0, 1);
        check({tag, "_idlebusy"}, sel ? b1 : b0, 0);
        check({tag, "_count"}, sel ? 32'(c1) : 32'(c0), 32'(last_cnt));
        check({tag, "_ovf"}, sel ? o1 : o0, 32'(last_ovf));
    endtask

    initial begin
        int p;
        logic [63:0] rp;

        // Reset with z toggling
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            z_in = ~z_in;
            step();
        end
        check("rst_valid", v0, 0);
        check("rst_count", c0, 0);
        check("rst_ovf", o0, 0);
        check("rst_busy", b0, 0);
        check("rst_valid1", v1, 0);
        check("rst_busy1", b1, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            z_in = 1'($urandom);
            step();
            check("idle_valid", v0, 0);
            check("idle_busy", b0, 0);
        end
        z_in = 1'b0;
        step();

        // Basic: three clean pulses, immediate accept
        start(1'b0, 1'b1, 1'b0, 1'b0, p);
        body(1'b0, 16, 64'h444, p, "basic");
        check("basic_exact3", c0, 3);
        hs(1'b0, 1'b0, 1'b0, "basic", p);

        // Boundary: edge in last window cycle, then in first report cycle
        start(1'b0, 1'b1, 1'b0, 1'b0, p);
        body(1'b0, 16, 64'h8000, p, "bnd_last");
        hs(1'b0, 1'b1, 1'b0, "bnd_last", p);
        body(1'b0, 16, 64'h10000, p, "bnd_late");
        hs(1'b0, 1'b1, 1'b1, "bnd_late", p);
        body(1'b0, 16, 64'h1, p, "bnd_clr");
        hs(1'b0, 1'b0, 1'b0, "bnd_clr", p);

        // Backpressure with z toggling during report
        start(1'b0, 1'b1, 1'b0, 1'b0, p);
        rp = {$urandom, $urandom};
        body(1'b0, 16, rp, p, "bp");
        for (int i = 0; i < 10; i++) begin
            z_in = ~z_in;
            step();
            check("bp_hold_valid", v0, 1);
            check("bp_hold_count", c0, 32'(last_cnt));
            check("bp_hold_ovf", o0, 32'(last_ovf));
        end
        hs(1'b0, 1'b0, 1'b0, "bp", p);
        check("bp_keep_count", c0, 32'(last_cnt));

        // Saturation on the narrow instance
        start(1'b1, 1'b1, 1'b0, 1'b0, p);
        body(1'b1, 32, 64'h4924, p, "sat5");
        check("sat5_cnt", c1, 3);
        check("sat5_flag", o1, 1);
        hs(1'b1, 1'b0, 1'b0, "sat5", p);
        start(1'b1, 1'b1, 1'b0, 1'b0, p);
        body(1'b1, 32, 64'h8, p, "sat1");
        check("sat1_cnt", c1, 1);
        check("sat1_flag", o1, 0);
        hs(1'b1, 1'b0, 1'b0, "sat1", p);

        // Random windows, random en on handshake
        start(1'b0, 1'b1, 1'($urandom), 1'b0, p);
        for (int k = 0; k < 4; k++) begin
            rp = {$urandom, $urandom};
            body(1'b0, 16, rp, p, "rnd");
            hs(1'b0, (k < 3) ? 1'($urandom) | 1'b1 : 1'b0,
               1'($urandom), "rnd", p);
        end

        // Reset in the middle of a window
        z_in = 1'b0;
        step();
        start(1'b0, 1'b1, 1'b0, 1'b0, p);
        rp = 64'ha;
        for (int i = 1; i <= 7; i++) begin
            z_in = rp[i];
            step();
        end
        rst = 1'b1;
        #1;
        check("mid_rst_valid", v0, 0);
        check("mid_rst_count", c0, 0);
        check("mid_rst_ovf", o0, 0);
        check("mid_rst_busy", b0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            z_in = 1'($urandom);
            step();
            check("mid_rst_noreport", v0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
